usb_ep_buffer: RTL

//  Multi-endpoint byte buffer between the AHB slave and the USB rx/tx engines; successor to the single 64-byte data buffer.

---
 rtl/usb_buf_pkg.sv | 28 ++
 rtl/usb_ep_fifo.sv | 85 ++++++++
 rtl/usb_ep_buffer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : usb_buf_pkg
// Description : Shared types and helpers for the multi-endpoint USB buffer.
//               Provides the AHB transfer-size encoding and its byte count.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_buf_pkg;

   typedef enum logic [1:0] {
      XFER_NONE = 2'd0,
      XFER_BYTE = 2'd1,
      XFER_HALF = 2'd2,
      XFER_WORD = 2'd3
   } xfer_size_t;

   // Number of bytes moved by one AHB access of the given size.
   function automatic logic [2:0] size_bytes(xfer_size_t s);
      case (s)
         XFER_BYTE: return 3'd1;
         XFER_HALF: return 3'd2;
         XFER_WORD: return 3'd4;
         default:   return 3'd0;
      endcase
   endfunction

endpackage : usb_buf_pkg
`default_nettype wire

// File: rtl/usb_ep_fifo.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_fifo
// Description : One circular byte FIFO of DEPTH entries. Executes at most one
//               push (1..4 bytes) and one pop (1..4 bytes) per cycle; the
//               parent has already decided that both are legal. o_peek shows
//               the four oldest bytes, byte0 = head.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_fifo #(
   parameter  int DEPTH = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_push_en,
   input  logic [2:0]       i_push_n,
   input  logic [31:0]      i_push_data,
   input  logic             i_pop_en,
   input  logic [2:0]       i_pop_n,
   output logic [OCC_W-1:0] o_count,
   output logic [31:0]      o_peek
);

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;
   logic [OCC_W-1:0] w_count_nxt;

   // Byte-lane writes into the storage array; contents need no reset since
   // a zero count hides them.
   always_ff @(posedge clk) begin
      if (i_push_en && !i_clr) begin
         for (int l = 0; l < 4; l++) begin
            if (l < int'(i_push_n)) begin
               r_mem[r_wr_ptr + PTR_W'(l)] <= i_push_data[8*l +: 8];
            end
         end
      end
   end

   // Four oldest bytes, wrapping modulo DEPTH.
   always_comb begin
      o_peek = '0;
      for (int l = 0; l < 4; l++) begin
         o_peek[8*l +: 8] = r_mem[r_rd_ptr + PTR_W'(l)];
      end
   end

   // Next occupancy: clear wins, otherwise add pushed and remove popped bytes.
   always_comb begin
      w_count_nxt = r_count;
      if (i_clr) begin
         w_count_nxt = '0;
      end else begin
         if (i_push_en) w_count_nxt = w_count_nxt + OCC_W'(i_push_n);
         if (i_pop_en)  w_count_nxt = w_count_nxt - OCC_W'(i_pop_n);
      end
   end

   // Pointer and count state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (i_push_en) r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_n);
            if (i_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_n);
         end
      end
   end

   assign o_count = r_count;

endmodule : usb_ep_fifo
`default_nettype wire

// File: rtl/usb_ep_buffer.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_buffer
// Description : NUM_EP independent DEPTH-byte FIFOs between the AHB slave
//               (1/2/4-byte accesses) and the USB rx/tx engines (1 byte per
//               cycle). Handles endpoint decode, same-endpoint collision
//               arbitration (USB side wins), and sticky overflow/underflow.
//               Optional macro USB_BUF_HWM_EN adds a per-endpoint high-water
//               mark readable through port hwm for ahb_ep.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_buffer
   import usb_buf_pkg::*;
#(
   parameter  int NUM_EP = 4,
   parameter  int DEPTH  = 64,
   localparam int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
   localparam int OCC_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [EP_W-1:0]   ahb_ep,
   input  logic [EP_W-1:0]   usb_ep,
   input  logic [1:0]        store_tx_data,
   input  logic [31:0]       tx_data,
   input  logic [1:0]        get_rx_data,
   output logic [31:0]       rx_data,
   input  logic              store_rx_packet_data,
   input  logic [7:0]        rx_packet_data,
   input  logic              get_tx_packet_data,
   output logic [7:0]        tx_packet_data,
   input  logic              clear,
   input  logic              flush,
   output logic [OCC_W-1:0]  buffer_occupancy,
   output logic [OCC_W-1:0]  usb_occupancy,
   output logic [NUM_EP-1:0] overflow,
   output logic [NUM_EP-1:0] underflow,
   input  logic              err_clr
`ifdef USB_BUF_HWM_EN
  ,output logic [OCC_W-1:0]  hwm
`endif
);

   logic [2:0] w_ahb_push_n;
   logic [2:0] w_ahb_pop_n;

   logic [NUM_EP-1:0] w_ahb_sel;
   logic [NUM_EP-1:0] w_usb_sel;
   logic [NUM_EP-1:0] w_ep_rst;
   logic [NUM_EP-1:0] w_usb_push_req;
   logic [NUM_EP-1:0] w_usb_pop_req;
   logic [NUM_EP-1:0] w_ahb_push_req;
   logic [NUM_EP-1:0] w_ahb_pop_req;
   logic [NUM_EP-1:0] w_usb_push_ok;
   logic [NUM_EP-1:0] w_usb_pop_ok;
   logic [NUM_EP-1:0] w_ahb_push_ok;
   logic [NUM_EP-1:0] w_ahb_pop_ok;
   logic [NUM_EP-1:0] w_ovf_set;
   logic [NUM_EP-1:0] w_unf_set;
   logic [NUM_EP-1:0] w_err_clr;
   logic [NUM_EP-1:0] w_push_en;
   logic [NUM_EP-1:0] w_pop_en;

   logic [NUM_EP-1:0][2:0]       w_push_n;
   logic [NUM_EP-1:0][2:0]       w_pop_n;
   logic [NUM_EP-1:0][31:0]      w_push_data;
   logic [NUM_EP-1:0][OCC_W-1:0] w_count;
   logic [NUM_EP-1:0][31:0]      w_peek;

   logic [31:0]       w_ahb_peek;
   logic [31:0]       w_rx_next;
   logic              w_rx_accept;
   logic [31:0]       r_rx_data;
   logic [NUM_EP-1:0] r_overflow;
   logic [NUM_EP-1:0] r_underflow;

   assign w_ahb_push_n = size_bytes(xfer_size_t'(store_tx_data));
   assign w_ahb_pop_n  = size_bytes(xfer_size_t'(get_rx_data));

   // Per-endpoint decode, admission checks (all against the pre-edge count)
   // and the FIFO instance. A clear/flush on an endpoint suppresses every
   // other op on it, so no request is raised and no flag can be set.
   for (genvar e = 0; e < NUM_EP; e++) begin : g_ep
      assign w_ahb_sel[e] = (ahb_ep == EP_W'(e));
      assign w_usb_sel[e] = (usb_ep == EP_W'(e));
      assign w_ep_rst[e]  = (clear && w_ahb_sel[e]) || (flush && w_usb_sel[e]);
      assign w_err_clr[e] = err_clr && w_ahb_sel[e];

      assign w_usb_push_req[e] = w_usb_sel[e] && store_rx_packet_data && !w_ep_rst[e];
      assign w_usb_pop_req[e]  = w_usb_sel[e] && get_tx_packet_data   && !w_ep_rst[e];
      assign w_ahb_push_req[e] = w_ahb_sel[e] && (w_ahb_push_n != 3'd0) && !w_ep_rst[e];
      assign w_ahb_pop_req[e]  = w_ahb_sel[e] && (w_ahb_pop_n  != 3'd0) && !w_ep_rst[e];

      assign w_usb_push_ok[e] = w_usb_push_req[e] && (32'(w_count[e]) + 32'd1 <= 32'(DEPTH));
      assign w_usb_pop_ok[e]  = w_usb_pop_req[e]  && (w_count[e] != '0);
      // A USB request on the same endpoint takes the slot even if it fails.
      assign w_ahb_push_ok[e] = w_ahb_push_req[e] && !w_usb_push_req[e] &&
                                (32'(w_count[e]) + 32'(w_ahb_push_n) <= 32'(DEPTH));
      assign w_ahb_pop_ok[e]  = w_ahb_pop_req[e] && !w_usb_pop_req[e] &&
                                (32'(w_count[e]) >= 32'(w_ahb_pop_n));

      assign w_ovf_set[e] = (w_usb_push_req[e] && !w_usb_push_ok[e]) ||
                            (w_ahb_push_req[e] && !w_ahb_push_ok[e]);
      assign w_unf_set[e] = (w_usb_pop_req[e] && !w_usb_pop_ok[e]) ||
                            (w_ahb_pop_req[e] && !w_ahb_pop_ok[e]);

      assign w_push_en[e]   = w_usb_push_ok[e] || w_ahb_push_ok[e];
      assign w_push_n[e]    = w_usb_push_ok[e] ? 3'd1 : w_ahb_push_n;
      assign w_push_data[e] = w_usb_push_ok[e] ? {24'd0, rx_packet_data} : tx_data;
      assign w_pop_en[e]    = w_usb_pop_ok[e] || w_ahb_pop_ok[e];
      assign w_pop_n[e]     = w_usb_pop_ok[e] ? 3'd1 : w_ahb_pop_n;

      usb_ep_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk         (clk),
         .rst         (rst),
         .i_clr       (w_ep_rst[e]),
         .i_push_en   (w_push_en[e]),
         .i_push_n    (w_push_n[e]),
         .i_push_data (w_push_data[e]),
         .i_pop_en    (w_pop_en[e]),
         .i_pop_n     (w_pop_n[e]),
         .o_count     (w_count[e]),
         .o_peek      (w_peek[e])
      );
   end

   // Endpoint-selected read-back; out-of-range selects read as zero.
   always_comb begin
      buffer_occupancy = '0;
      usb_occupancy    = '0;
      tx_packet_data   = '0;
      w_ahb_peek       = '0;
      for (int e = 0; e < NUM_EP; e++) begin
         if (w_ahb_sel[e]) begin
            buffer_occupancy = w_count[e];
            w_ahb_peek       = w_peek[e];
         end
         if (w_usb_sel[e]) begin
            usb_occupancy = w_count[e];
            if (w_count[e] != '0) tx_packet_data = w_peek[e][7:0];
         end
      end
   end

   assign w_rx_accept = |w_ahb_pop_ok;

   // Keep only the lanes actually popped; the rest read as zero.
   always_comb begin
      case (w_ahb_pop_n)
         3'd1:    w_rx_next = {24'd0, w_ahb_peek[7:0]};
         3'd2:    w_rx_next = {16'd0, w_ahb_peek[15:0]};
         default: w_rx_next = w_ahb_peek;
      endcase
   end

   // AHB pop result register; unchanged when the pop is refused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_data <= '0;
      end else if (w_rx_accept) begin
         r_rx_data <= w_rx_next;
      end
   end

   // Sticky error flags; a new error in the same cycle beats err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= '0;
         r_underflow <= '0;
      end else begin
         r_overflow  <= (r_overflow  & ~w_err_clr) | w_ovf_set;
         r_underflow <= (r_underflow & ~w_err_clr) | w_unf_set;
      end
   end

   assign rx_data   = r_rx_data;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

`ifdef USB_BUF_HWM_EN
   logic [NUM_EP-1:0][OCC_W-1:0] r_hwm;
   logic [NUM_EP-1:0][OCC_W-1:0] w_hwm_cnt_nxt;
   logic [NUM_EP-1:0][OCC_W-1:0] w_hwm_base;
   logic [NUM_EP-1:0][OCC_W-1:0] w_hwm_nxt;

   // Post-edge count of each endpoint and the mark it would produce; an
   // AHB clear restarts the mark for that endpoint.
   for (genvar e = 0; e < NUM_EP; e++) begin : g_hwm
      assign w_hwm_cnt_nxt[e] = w_ep_rst[e] ? '0 :
                                OCC_W'(32'(w_count[e])
                                       + (w_push_en[e] ? 32'(w_push_n[e]) : 32'd0)
                                       - (w_pop_en[e]  ? 32'(w_pop_n[e])  : 32'd0));
      assign w_hwm_base[e]    = (clear && w_ahb_sel[e]) ? '0 : r_hwm[e];
      assign w_hwm_nxt[e]     = (w_hwm_cnt_nxt[e] > w_hwm_base[e]) ? w_hwm_cnt_nxt[e]
                                                                    : w_hwm_base[e];
   end

   // High-water mark registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hwm <= '0;
      end else begin
         r_hwm <= w_hwm_nxt;
      end
   end

   // Mark of the AHB-selected endpoint.
   always_comb begin
      hwm = '0;
      for (int e = 0; e < NUM_EP; e++) begin
         if (w_ahb_sel[e]) hwm = r_hwm[e];
      end
   end
`endif

endmodule : usb_ep_buffer
`default_nettype wire
